reg_list_decoder_seq: RTL

- Parametrised successor to the combinational 4-to-16 select decoder.
- Accepts either a single select index or a register-list bitmask, and emits one one-hot select per cycle.
- List mode walks the set bits in ascending or descending order.
- Sits between instruction decode and the register file. It drives per-register write/read enables for single-register and block-transfer (load/store multiple) operations.

---
 rtl/reg_list_decoder_seq.sv | 118 +++++++++++
 1 files changed

// File: rtl/reg_list_decoder_seq.sv
// Sequential one-hot register select: emits either a single index or, in list mode,
// each set bit of a register mask in priority order, one per cycle.
module reg_list_decoder_seq #(
  parameter int SEL_W = 4,
  parameter int ORDER = 0,
  localparam int OUT_W = 2**SEL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel_in,
  input  logic [OUT_W-1:0] list_in,
  output logic [OUT_W-1:0] out,
  output logic [SEL_W-1:0] idx,
  output logic             out_valid,
  output logic             busy,
  output logic             done,
  output logic [SEL_W:0]   count
);

  localparam logic [SEL_W:0]   CNT_ONE  = {{SEL_W{1'b0}}, 1'b1};
  localparam logic [OUT_W-1:0] HOT_ONE  = {{(OUT_W-1){1'b0}}, 1'b1};
  localparam logic [OUT_W-1:0] MASK_ZERO = {OUT_W{1'b0}};

  logic [OUT_W-1:0] pending_q, pending_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;
  logic [SEL_W:0]   count_q, count_d;

  logic             accept_s;
  logic [OUT_W-1:0] src_s;
  logic [SEL_W-1:0] pick_idx_s;
  logic [OUT_W-1:0] pick_hot_s;

  // Priority pick: the scan order is chosen so the winning bit is the last one written.
  function automatic logic [SEL_W-1:0] pick(input logic [OUT_W-1:0] m);
    logic [SEL_W-1:0] r;
    int j;
    r = {SEL_W{1'b0}};
    for (int i = 0; i < OUT_W; i++) begin
      j = (ORDER == 0) ? (OUT_W - 1 - i) : i;
      if (m[j]) begin
        r = SEL_W'(j);
      end
    end
    return r;
  endfunction

  function automatic logic [OUT_W-1:0] onehot(input logic [SEL_W-1:0] s);
    return HOT_ONE << s;
  endfunction

  assign busy       = (pending_q != MASK_ZERO);
  assign accept_s   = start & ~busy;
  assign src_s      = accept_s ? list_in : pending_q;
  assign pick_idx_s = pick(src_s);
  assign pick_hot_s = onehot(pick_idx_s);

  // Next-state: single select, list element (first from list_in, later from pending), or idle.
  always_comb begin
    pending_d = MASK_ZERO;
    out_d     = MASK_ZERO;
    idx_d     = {SEL_W{1'b0}};
    valid_d   = 1'b0;
    done_d    = 1'b0;
    count_d   = count_q;
    if (accept_s && mode) begin
      out_d   = onehot(sel_in);
      idx_d   = sel_in;
      valid_d = 1'b1;
      done_d  = 1'b1;
      count_d = CNT_ONE;
    end else if (accept_s || busy) begin
      if (src_s != MASK_ZERO) begin
        out_d     = pick_hot_s;
        idx_d     = pick_idx_s;
        valid_d   = 1'b1;
        pending_d = src_s & ~pick_hot_s;
        done_d    = (pending_d == MASK_ZERO);
        count_d   = accept_s ? CNT_ONE : (count_q + CNT_ONE);
      end else begin
        done_d  = 1'b1;
        count_d = {(SEL_W+1){1'b0}};
      end
    end else begin
      count_d = count_q;
    end
  end

  // State and output registers; reset discards any list in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= MASK_ZERO;
      out_q     <= MASK_ZERO;
      idx_q     <= {SEL_W{1'b0}};
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      count_q   <= {(SEL_W+1){1'b0}};
    end else begin
      pending_q <= pending_d;
      out_q     <= out_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      count_q   <= count_d;
    end
  end

  assign out       = out_q;
  assign idx       = idx_q;
  assign out_valid = valid_q;
  assign done      = done_q;
  assign count     = count_q;

endmodule
